// File: rtl/cache_rd_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cache_rd_arbiter_pkg
//  Description : Shared constants and state encoding for the shared-cache
//                read-port arbiter and its rotating picker.
//  Revision    : 1.0 - initial release
// ============================================================================
package cache_rd_arbiter_pkg;

    // Default number of output modules sharing the cache read port
    localparam int c_port_nub_total = 16;

    // Number of distinct priority levels a port weight can express
    localparam int c_priority = 8;

    // Derived widths: owner index and per-port weight
    localparam int c_width_sel    = $clog2(c_port_nub_total);
    localparam int c_width_wieght = $clog2(c_priority);

    // Default watchdog limit on a single grant, in HOLD cycles
    localparam int c_timeout = 1024;

    // Arbiter states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RELOAD = 2'd1,
        HOLD   = 2'd2
    } arb_state_t;

endpackage : cache_rd_arbiter_pkg
`default_nettype wire

// File: rtl/cache_rd_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : cache_rd_arbiter_rr_pick
//  Description : Combinational rotating priority encoder. Returns the first
//                set bit of the eligible mask, scanning upward from rr_ptr
//                and wrapping modulo PORT_NUB.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_rd_arbiter_rr_pick #(
    parameter int PORT_NUB  = 16,
    parameter int WIDTH_SEL = 4
) (
    input  logic [PORT_NUB-1:0]  eligible,
    input  logic [WIDTH_SEL-1:0] rr_ptr,
    output logic [WIDTH_SEL-1:0] index,
    output logic                 found
);

    localparam logic [WIDTH_SEL:0] c_port_nub = (WIDTH_SEL+1)'(PORT_NUB);

    // Scan position, one bit wider than the index so the wrap can be detected
    logic [WIDTH_SEL:0] w_pos;

    // Walk the ports in rotated order and keep the first eligible one
    always_comb begin
        index = '0;
        found = 1'b0;
        w_pos = '0;
        for (int k = 0; k < PORT_NUB; k++) begin
            w_pos = {1'b0, rr_ptr} + (WIDTH_SEL+1)'(k);
            if (w_pos >= c_port_nub) begin
                w_pos = w_pos - c_port_nub;
            end
            if (!found && eligible[w_pos[WIDTH_SEL-1:0]]) begin
                found = 1'b1;
                index = w_pos[WIDTH_SEL-1:0];
            end
        end
    end

endmodule : cache_rd_arbiter_rr_pick
`default_nettype wire

// File: rtl/cache_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cache_rd_arbiter
//  Description : Grants the shared-cache read port to one of PORT_NUB output
//                modules and locks the grant for a whole packet, until the
//                owner pulses done or the watchdog expires. Policy is strict
//                priority by weight or credit-based weighted round-robin.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_rd_arbiter
    import cache_rd_arbiter_pkg::*;
#(
    parameter int PORT_NUB     = c_port_nub_total,
    parameter int WIDTH_WIEGHT = c_width_wieght,
    parameter int TIMEOUT      = c_timeout
) (
    input  logic                             internal_clk,
    input  logic                             rst_n,
    input  logic [PORT_NUB-1:0]              req_in,
    input  logic [PORT_NUB-1:0]              done_in,
    input  logic                             dispatch_sel,
    input  logic [PORT_NUB*WIDTH_WIEGHT-1:0] wieght_in,
    output logic [PORT_NUB-1:0]              grant_out,
    output logic                             grant_vld,
    output logic [$clog2(PORT_NUB)-1:0]      grant_port,
    output logic                             timeout_err
);

    localparam int c_wsel    = $clog2(PORT_NUB);
    localparam int c_wcredit = WIDTH_WIEGHT + 1;   // holds weight+1
    localparam int c_whold   = $clog2(TIMEOUT);

    localparam logic [c_whold-1:0]  c_hold_last   = c_whold'(TIMEOUT - 1);
    localparam logic [c_wsel-1:0]   c_port_last   = c_wsel'(PORT_NUB - 1);
    localparam logic [PORT_NUB-1:0] c_onehot_base = PORT_NUB'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    arb_state_t           r_state;
    logic [c_wsel-1:0]    r_rr_ptr;
    logic [c_whold-1:0]   r_hold_cnt;
    logic [c_wcredit-1:0] r_credit [PORT_NUB];

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [WIDTH_WIEGHT-1:0] w_weight [PORT_NUB];
    logic [PORT_NUB-1:0]     w_eligible;
    logic [PORT_NUB-1:0]     w_pick_mask;
    logic [c_wsel-1:0]       w_rr_idx;
    logic                    w_rr_found;
    logic [c_wsel-1:0]       w_sp_idx;
    logic [WIDTH_WIEGHT-1:0] w_sp_best;
    logic                    w_sp_any;

    // Unpack weights and flag requesters that still hold WRR credit
    generate
        for (genvar gi = 0; gi < PORT_NUB; gi++) begin : g_port
            assign w_weight[gi]   = wieght_in[gi*WIDTH_WIEGHT +: WIDTH_WIEGHT];
            assign w_eligible[gi] = req_in[gi] & (r_credit[gi] != '0);
        end
    endgenerate

    // In RELOAD every requester is about to be refilled, so all of them count
    assign w_pick_mask = (r_state == RELOAD) ? req_in : w_eligible;

    cache_rd_arbiter_rr_pick #(
        .PORT_NUB  (PORT_NUB),
        .WIDTH_SEL (c_wsel)
    ) u_rr_pick (
        .eligible (w_pick_mask),
        .rr_ptr   (r_rr_ptr),
        .index    (w_rr_idx),
        .found    (w_rr_found)
    );

    // Strict priority: largest weight wins, strict '>' keeps ties on the lowest index
    always_comb begin
        w_sp_idx  = '0;
        w_sp_best = '0;
        w_sp_any  = 1'b0;
        for (int i = 0; i < PORT_NUB; i++) begin
            if (req_in[i] && (!w_sp_any || (w_weight[i] > w_sp_best))) begin
                w_sp_any  = 1'b1;
                w_sp_best = w_weight[i];
                w_sp_idx  = c_wsel'(i);
            end
        end
    end

    // Arbiter FSM: pick an owner, lock it for the packet, release on done or watchdog
    always_ff @(posedge internal_clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_hold_cnt  <= '0;
            grant_out   <= '0;
            grant_vld   <= 1'b0;
            grant_port  <= '0;
            timeout_err <= 1'b0;
            for (int i = 0; i < PORT_NUB; i++) begin
                r_credit[i] <= '0;
            end
        end else begin
            timeout_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_in != '0) begin
                        if (dispatch_sel) begin
                            grant_out  <= c_onehot_base << w_sp_idx;
                            grant_vld  <= 1'b1;
                            grant_port <= w_sp_idx;
                            r_state    <= HOLD;
                        end else if (w_rr_found) begin
                            grant_out            <= c_onehot_base << w_rr_idx;
                            grant_vld            <= 1'b1;
                            grant_port           <= w_rr_idx;
                            r_credit[w_rr_idx]   <= r_credit[w_rr_idx] - 1'b1;
                            r_rr_ptr             <= (w_rr_idx == c_port_last) ? '0 : w_rr_idx + 1'b1;
                            r_state              <= HOLD;
                        end else begin
                            r_state <= RELOAD;
                        end
                    end
                end

                // Refill every credit and, in the same cycle, arbitrate among
                // the refilled requesters so a reload costs exactly one cycle
                RELOAD: begin
                    for (int i = 0; i < PORT_NUB; i++) begin
                        r_credit[i] <= c_wcredit'(w_weight[i]) + 1'b1;
                    end
                    if (w_rr_found) begin
                        r_credit[w_rr_idx] <= c_wcredit'(w_weight[w_rr_idx]);
                        grant_out          <= c_onehot_base << w_rr_idx;
                        grant_vld          <= 1'b1;
                        grant_port         <= w_rr_idx;
                        r_rr_ptr           <= (w_rr_idx == c_port_last) ? '0 : w_rr_idx + 1'b1;
                        r_state            <= HOLD;
                    end else begin
                        r_state <= IDLE;
                    end
                end

                // Only the owner's done matters; done wins over a same-cycle timeout
                HOLD: begin
                    if (done_in[grant_port]) begin
                        grant_out  <= '0;
                        grant_vld  <= 1'b0;
                        r_hold_cnt <= '0;
                        r_state    <= IDLE;
                    end else if (r_hold_cnt == c_hold_last) begin
                        grant_out   <= '0;
                        grant_vld   <= 1'b0;
                        r_hold_cnt  <= '0;
                        timeout_err <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : cache_rd_arbiter
`default_nettype wire

// File: tb/tb_cache_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_rd_arbiter
//  Description : Scoreboard bench for cache_rd_arbiter. Stimulus predicts each
//                grant with a reference model and queues it; a monitor checks
//                owner, latency, hold length and timeout pulse as they occur.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_rd_arbiter;

    localparam int N  = 16;
    localparam int WW = 3;
    localparam int TO = 16;
    localparam int WS = 4;

    logic            internal_clk = 1'b0;
    logic            rst_n        = 1'b0;
    logic [N-1:0]    req_in       = '0;
    logic [N-1:0]    done_in      = '0;
    logic            dispatch_sel = 1'b0;
    logic [N*WW-1:0] wieght_in    = '0;
    logic [N-1:0]    grant_out;
    logic            grant_vld;
    logic [WS-1:0]   grant_port;
    logic            timeout_err;

    cache_rd_arbiter #(
        .PORT_NUB     (N),
        .WIDTH_WIEGHT (WW),
        .TIMEOUT      (TO)
    ) dut (
        .internal_clk (internal_clk),
        .rst_n        (rst_n),
        .req_in       (req_in),
        .done_in      (done_in),
        .dispatch_sel (dispatch_sel),
        .wieght_in    (wieght_in),
        .grant_out    (grant_out),
        .grant_vld    (grant_vld),
        .grant_port   (grant_port),
        .timeout_err  (timeout_err)
    );

    always #5 internal_clk = ~internal_clk;

    typedef struct {
        int port;
        int lat;
        int hold;
        int to;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   grant_cnt[N];

    // Reference model state
    int   m_credit[N];
    int   m_ptr;
    int   m_w[N];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) m_credit[i] = 0;
        m_ptr = 0;
    endfunction

    // Highest weight wins, ties to the lowest port number
    function automatic int sp_model(input logic [N-1:0] req);
        int win = -1;
        for (int i = 0; i < N; i++)
            if (req[i] && (win < 0 || m_w[i] > m_w[win])) win = i;
        return win;
    endfunction

    // Credit WRR: refill (one extra cycle) only when no requester has credit
    function automatic void wrr_model(input logic [N-1:0] req, output int win, output int lat);
        bit any = 0;
        lat = 1;
        for (int i = 0; i < N; i++) if (req[i] && m_credit[i] > 0) any = 1;
        if (!any) begin
            for (int i = 0; i < N; i++) m_credit[i] = m_w[i] + 1;
            lat = 2;
        end
        win = -1;
        for (int k = 0; k < N; k++)
            if (win < 0 && req[(m_ptr + k) % N] && m_credit[(m_ptr + k) % N] > 0) win = (m_ptr + k) % N;
        m_credit[win] = m_credit[win] - 1;
        m_ptr = (win + 1) % N;
    endfunction

    task automatic set_weight(input int port, input int w);
        m_w[port] = w;
        wieght_in[port*WW +: WW] = WW'(w);
    endtask

    task automatic set_weights_random();
        for (int i = 0; i < N; i++) set_weight(i, $urandom_range(0, 7));
    endtask

    task automatic do_reset(input int cyc);
        rst_n   = 1'b0;
        req_in  = '0;
        done_in = '0;
        repeat (cyc) @(negedge internal_clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // One packet: predict, queue, request, hold for d cycles (d=0: never done).
    // noise 1 = random junk on non-owner inputs; 2 = owner drops req, port5 pulses done.
    // kill_at > 0 asserts reset during that HOLD cycle.
    task automatic txn(input logic [N-1:0] req, input bit sel, input int d,
                       input int noise, input int kill_at);
        exp_t e;
        int   win;
        int   lat;
        int   c;
        int   other;
        bit   ok;
        if (sel) begin
            win = sp_model(req);
            lat = 1;
        end else begin
            wrr_model(req, win, lat);
        end
        e.port = win;
        e.lat  = lat;
        if (kill_at > 0) begin
            e.hold = kill_at; e.to = 0;
        end else if (d > 0 && d <= TO) begin
            e.hold = d; e.to = 0;
        end else begin
            e.hold = TO; e.to = 1;
        end
        exp_q.push_back(e);
        req_in       = req;
        dispatch_sel = sel;
        ok = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge internal_clk);
            if (grant_vld) begin
                ok = 1;
                break;
            end
        end
        check("grant_arrives", int'(ok), 1);
        if (!ok) begin
            void'(exp_q.pop_back());
            req_in = '0;
            return;
        end
        c = 1;
        forever begin
            done_in = '0;
            if (noise == 1) begin
                req_in       = N'($urandom);
                dispatch_sel = 1'($urandom);
                other        = (win + 1 + $urandom_range(0, N - 2)) % N;
                done_in[other] = 1'($urandom);
            end else if (noise == 2) begin
                if (c == 1) req_in = 16'h0020;
                if (c == 2) done_in[5] = 1'b1;
            end
            if (kill_at == c) rst_n = 1'b0;
            else if (d == c) done_in[win] = 1'b1;
            @(negedge internal_clk);
            done_in = '0;
            if (kill_at == c) begin
                rst_n  = 1'b1;
                req_in = '0;
                model_reset();
                break;
            end
            if (!grant_vld) break;
            c++;
            if (c > TO + 4) begin
                check("release_bound", c, TO);
                break;
            end
        end
        req_in = '0;
    endtask

    // ------------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------------
    bit   gv_prev = 0;
    int   pend    = 0;
    int   hold    = 0;
    bit   have    = 0;
    exp_t cur;

    initial begin : monitor
        for (int i = 0; i < N; i++) grant_cnt[i] = 0;
        forever begin
            @(posedge internal_clk);
            #1;
            check("onehot", int'($countones(grant_out) <= 1), 1);
            check("vld_vs_out", int'(grant_vld), int'(|grant_out));
            if (!rst_n) pend = 0;
            else if (req_in != '0 && !gv_prev) pend++;
            if (grant_vld && !gv_prev) begin
                hold = 1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    have = 0;
                    $display("FAIL unexpected_grant: port %0d granted, none expected", grant_port);
                end else begin
                    cur  = exp_q.pop_front();
                    have = 1;
                    check("grant_port", int'(grant_port), cur.port);
                    check("grant_onehot_pos", int'(grant_out), 1 << cur.port);
                    check("grant_latency", pend, cur.lat);
                    grant_cnt[grant_port]++;
                end
                pend = 0;
            end else if (grant_vld) begin
                hold++;
                if (have) check("grant_lock", int'(grant_port), cur.port);
            end
            if (!grant_vld && gv_prev) begin
                if (have) begin
                    check("hold_cycles", hold, cur.hold);
                    check("timeout_err", int'(timeout_err), cur.to);
                end
                have = 0;
            end else begin
                check("timeout_err_quiet", int'(timeout_err), 0);
            end
            if (!rst_n) begin
                check("reset_grant_out", int'(grant_out), 0);
                check("reset_grant_port", int'(grant_port), 0);
            end
            gv_prev = grant_vld;
        end
    end

    initial begin : global_guard
        #2000000;
        $display("FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1, "global timeout");
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    int c0_base;
    int c1_base;
    logic [N-1:0] rreq;

    initial begin : stimulus
        for (int i = 0; i < N; i++) set_weight(i, 0);
        model_reset();
        do_reset(3);

        // No requests: nothing may be granted for 100 cycles
        repeat (100) @(negedge internal_clk);
        check("idle_grant_vld", int'(grant_vld), 0);

        // WRR 2:1 between port0 (w=1) and port1 (w=0)
        set_weights_random();
        set_weight(0, 1);
        set_weight(1, 0);
        c0_base = grant_cnt[0];
        c1_base = grant_cnt[1];
        for (int i = 0; i < 30; i++) txn(16'h0003, 1'b0, 1, 0, 0);
        check("wrr_ratio_port0", grant_cnt[0] - c0_base, 20);
        check("wrr_ratio_port1", grant_cnt[1] - c1_base, 10);

        // Strict priority: 3 and 7 tie at weight 5, 9 has 2
        for (int i = 0; i < N; i++) set_weight(i, 0);
        set_weight(3, 5);
        set_weight(7, 5);
        set_weight(9, 2);
        txn(16'h0288, 1'b1, 2, 0, 0);
        txn(16'h0280, 1'b1, 3, 0, 0);
        txn(16'h0200, 1'b1, 1, 0, 0);

        // Lock: port2 owner keeps the grant despite req drop and port5 done
        txn(16'h0004, 1'b1, 4, 2, 0);

        // Watchdog: no done, done on the last allowed cycle, done one earlier
        txn(16'h0010, 1'b1, 0, 0, 0);
        txn(16'h0010, 1'b1, TO, 0, 0);
        txn(16'h0010, 1'b1, TO - 1, 0, 0);

        // Reset during HOLD, then the first WRR decision needs a reload
        txn(16'h0101, 1'b0, 0, 0, 3);
        txn(16'h0440, 1'b0, 1, 0, 0);

        // Randomized mix of policies, weights, hold lengths and junk inputs
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 2) == 0) set_weights_random();
            rreq = N'($urandom);
            if (rreq == '0) rreq = N'(1 << $urandom_range(0, N - 1));
            txn(rreq, 1'($urandom), $urandom_range(0, TO + 2), 1, 0);
        end

        repeat (5) @(negedge internal_clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_cache_rd_arbiter
`default_nettype wire
